// File: rtl/multi_channel_accumulator.sv
// multi_channel_accumulator
//   Accepts (channel, value) transactions over a valid/ready handshake, holds
//   each for WAIT_CYCLES cycles, then adds the value into one of NUM_CH
//   per-channel accumulators.
//
//   Optional feature macro: MULTI_CHANNEL_ACCUMULATOR_SATURATE_EN
//     defined   -> on carry-out the accumulator saturates to all-ones
//     undefined -> on carry-out the accumulator wraps modulo 2^WIDTH
//     In both builds the channel's sticky ovf bit is set on carry-out.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   in_valid/in_ready   transaction handshake (accept when both high in IDLE)
//   in_ch, in_value     target channel and addend, sampled at accept only
//   clr_valid, clr_ch   zero acc[clr_ch] and ovf[clr_ch] at the edge, any state
//   led_sel, led        LED window of acc[led_sel] (combinational)
//   rd_ch, rd_data      full read of acc[rd_ch] (combinational)
//   ovf                 per-channel sticky overflow flags
//   done                one-cycle pulse after an accumulation commits
module multi_channel_accumulator #(
  parameter  int WIDTH       = 32,
  parameter  int NUM_CH      = 4,
  parameter  int WAIT_CYCLES = 1,
  parameter  int LED_W       = 8,
  parameter  int LED_LSB     = 16,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [WIDTH-1:0]  in_value,
  input  logic              clr_valid,
  input  logic [CH_W-1:0]   clr_ch,
  input  logic [CH_W-1:0]   led_sel,
  output logic [LED_W-1:0]  led,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCUM
  } state_t;

  // The counter is loaded with WAIT_CYCLES-1 so that WAIT lasts exactly
  // WAIT_CYCLES cycles; zero wait skips WAIT altogether.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);

  state_t            state;
  state_t            state_next;
  logic [3:0]        wait_cnt;
  logic [CH_W-1:0]   cap_ch;
  logic [WIDTH-1:0]  cap_value;
  logic [WIDTH-1:0]  acc [NUM_CH];
  logic [WIDTH:0]    sum;
  logic              carry;
  logic [WIDTH-1:0]  acc_new;
  logic [WIDTH-1:0]  led_word;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake output
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = HAS_WAIT ? S_WAIT : S_ACCUM;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) begin
          state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Adder with carry-out for the captured channel
  always_comb begin
    sum   = {1'b0, acc[cap_ch]} + {1'b0, cap_value};
    carry = sum[WIDTH];
`ifdef MULTI_CHANNEL_ACCUMULATOR_SATURATE_EN
    acc_new = carry ? '1 : sum[WIDTH-1:0];
`else
    acc_new = sum[WIDTH-1:0];
`endif
  end

  // Datapath: capture, wait counter, accumulators, flags, done
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt  <= '0;
      cap_ch    <= '0;
      cap_value <= '0;
      done      <= 1'b0;
      ovf       <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
    end else begin
      done <= (state == S_ACCUM);

      if (state == S_IDLE && in_valid) begin
        cap_ch    <= in_ch;
        cap_value <= in_value;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == S_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (state == S_ACCUM && cap_ch == CH_W'(i)) begin
          acc[i] <= acc_new;
          if (carry) begin
            ovf[i] <= 1'b1;
          end
        end
        // Clear is applied after the update so it wins on the same channel.
        if (clr_valid && clr_ch == CH_W'(i)) begin
          acc[i] <= '0;
          ovf[i] <= 1'b0;
        end
      end
    end
  end

  // Read ports show registered state only
  assign rd_data  = acc[rd_ch];
  assign led_word = acc[led_sel];
  assign led      = led_word[LED_LSB +: LED_W];

endmodule

// File: tb/tb_multi_channel_accumulator.sv
module tb_multi_channel_accumulator;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ch = '0;
  logic [31:0] in_value = '0;
  logic        clr_valid = 1'b0;
  logic [1:0]  clr_ch = '0;
  logic [1:0]  led_sel = '0;
  logic [1:0]  rd_ch = '0;

  logic        in_ready, in_ready_w0, in_ready_w4;
  logic [7:0]  led, led_w0, led_w4;
  logic [31:0] rd_data, rd_data_w0, rd_data_w4;
  logic [3:0]  ovf, ovf_w0, ovf_w4;
  logic        done, done_w0, done_w4;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  multi_channel_accumulator #(
    .WIDTH(32), .NUM_CH(4), .WAIT_CYCLES(1), .LED_W(8), .LED_LSB(16)
  ) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_value(in_value), .clr_valid(clr_valid), .clr_ch(clr_ch),
    .led_sel(led_sel), .led(led), .rd_ch(rd_ch), .rd_data(rd_data),
    .ovf(ovf), .done(done)
  );

  multi_channel_accumulator #(
    .WIDTH(32), .NUM_CH(4), .WAIT_CYCLES(0), .LED_W(8), .LED_LSB(16)
  ) dut_w0 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_w0),
    .in_ch(in_ch), .in_value(in_value), .clr_valid(clr_valid), .clr_ch(clr_ch),
    .led_sel(led_sel), .led(led_w0), .rd_ch(rd_ch), .rd_data(rd_data_w0),
    .ovf(ovf_w0), .done(done_w0)
  );

  multi_channel_accumulator #(
    .WIDTH(32), .NUM_CH(4), .WAIT_CYCLES(4), .LED_W(8), .LED_LSB(16)
  ) dut_w4 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_w4),
    .in_ch(in_ch), .in_value(in_value), .clr_valid(clr_valid), .clr_ch(clr_ch),
    .led_sel(led_sel), .led(led_w4), .rd_ch(rd_ch), .rd_data(rd_data_w4),
    .ovf(ovf_w4), .done(done_w4)
  );

  // Reference model of the WAIT_CYCLES=1 instance
  logic [31:0] m_acc [4];
  logic [3:0]  m_ovf;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] acc;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    m_ovf = '0;
  endfunction

  function automatic void model_add(input logic [1:0] ch, input logic [31:0] v);
    logic [32:0] s;
    s = {1'b0, m_acc[ch]} + {1'b0, v};
    if (s[32]) begin
      m_ovf[ch] = 1'b1;
`ifdef MULTI_CHANNEL_ACCUMULATOR_SATURATE_EN
      m_acc[ch] = 32'hFFFF_FFFF;
`else
      m_acc[ch] = s[31:0];
`endif
    end else begin
      m_acc[ch] = s[31:0];
    end
  endfunction

  function automatic void model_clear(input logic [1:0] ch);
    m_acc[ch] = '0;
    m_ovf[ch] = 1'b0;
  endfunction

  function automatic void push_exp(input logic [1:0] ch);
    exp_t e;
    e.ch  = ch;
    e.acc = m_acc[ch];
    e.ovf = m_ovf[ch];
    sb.push_back(e);
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e.ch = '0; e.acc = 32'hxxxx_xxxx; e.ovf = 1'bx;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_all();
    RST = 1'b1;
    in_valid = 1'b0;
    clr_valid = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    model_reset();
    sb.delete();
  endtask

  // Returns after the accept edge
  task automatic send(input logic [1:0] ch, input logic [31:0] v);
    in_ch = ch;
    in_value = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_value = 32'hDEAD_BEEF;
    in_ch = ~ch;
  endtask

  // Cycles from the accept edge until done is seen, bounded at 20
  task automatic wait_done(input int sel, output int lat);
    logic d;
    lat = 0;
    d = 1'b0;
    while (!d && lat < 20) begin
      tick();
      lat++;
      d = (sel == 0) ? done : (sel == 1) ? done_w0 : done_w4;
    end
  endtask

  task automatic test_reset();
    reset_all();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ovf !== 4'h0) begin failures++; $display("FAIL reset_ovf got=%h exp=0", ovf); end
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      #1;
      checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_acc%0d got=%h exp=0", c, rd_data); end
    end
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", led); end
  endtask

  task automatic test_single();
    exp_t e;
    led_sel = 2'd2;
    rd_ch = 2'd2;
    model_add(2'd2, 32'h0001_0000);
    push_exp(2'd2);
    send(2'd2, 32'h0001_0000);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL single_ready_c1 got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL single_c2 ready=%b done=%b exp=0/0", in_ready, done); end
    tick();
    checks++; if (done !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL single_c3 done=%b ready=%b exp=1/1", done, in_ready); end
    e = pop_exp();
    checks++; if (rd_data !== e.acc) begin failures++; $display("FAIL single_acc2 got=%h exp=%h", rd_data, e.acc); end
    checks++; if (ovf[2] !== e.ovf) begin failures++; $display("FAIL single_ovf2 got=%b exp=%b", ovf[2], e.ovf); end
    checks++; if (led !== 8'h01) begin failures++; $display("FAIL single_led got=%h exp=01", led); end
    for (int c = 0; c < 4; c++) begin
      if (c == 2) continue;
      rd_ch = 2'(c);
      #1;
      checks++; if (rd_data !== m_acc[c]) begin failures++; $display("FAIL single_other%0d got=%h exp=%h", c, rd_data, m_acc[c]); end
    end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int accepts = 0;
    int dones = 0;
    int first_done = -1;
    int last_done = -1;
    bit spacing_ok = 1'b1;
    rd_ch = 2'd0;
    in_ch = 2'd0;
    in_value = 32'd5;
    in_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      if (in_ready) begin
        accepts++;
        model_add(2'd0, 32'd5);
        push_exp(2'd0);
      end
      tick();
      if (done) begin
        dones++;
        e = pop_exp();
        checks++; if (rd_data !== e.acc) begin failures++; $display("FAIL b2b_acc0 got=%h exp=%h", rd_data, e.acc); end
        if (first_done < 0) first_done = c;
        if (last_done >= 0 && c - last_done != 3) spacing_ok = 1'b0;
        last_done = c;
      end
    end
    in_valid = 1'b0;
    checks++; if (accepts != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", accepts); end
    checks++; if (dones != 3) begin failures++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
    checks++; if (first_done != 3 || !spacing_ok) begin failures++; $display("FAIL b2b_spacing first=%0d ok=%0d exp=3/1", first_done, spacing_ok); end
    checks++; if (rd_data !== 32'd15) begin failures++; $display("FAIL b2b_final got=%h exp=0000000f", rd_data); end
  endtask

  task automatic test_wrap();
    exp_t e;
    int lat;
    rd_ch = 2'd1;
    model_add(2'd1, 32'hFFFF_FFF0);
    push_exp(2'd1);
    send(2'd1, 32'hFFFF_FFF0);
    wait_done(0, lat);
    e = pop_exp();
    checks++; if (lat != 2 || rd_data !== e.acc) begin failures++; $display("FAIL wrap_preload lat=%0d got=%h exp=2/%h", lat, rd_data, e.acc); end
    model_add(2'd1, 32'h20);
    push_exp(2'd1);
    send(2'd1, 32'h20);
    wait_done(0, lat);
    e = pop_exp();
    checks++; if (rd_data !== e.acc) begin failures++; $display("FAIL wrap_acc1 got=%h exp=%h", rd_data, e.acc); end
`ifdef MULTI_CHANNEL_ACCUMULATOR_SATURATE_EN
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_sat got=%h exp=ffffffff", rd_data); end
`else
    checks++; if (rd_data !== 32'h0000_0010) begin failures++; $display("FAIL wrap_mod got=%h exp=00000010", rd_data); end
`endif
    checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL wrap_ovf got=%h exp=%h", ovf, m_ovf); end
    model_add(2'd1, 32'h1);
    push_exp(2'd1);
    send(2'd1, 32'h1);
    wait_done(0, lat);
    e = pop_exp();
    checks++; if (rd_data !== e.acc || ovf[1] !== e.ovf) begin failures++; $display("FAIL wrap_sticky acc=%h ovf=%b exp=%h/%b", rd_data, ovf[1], e.acc, e.ovf); end
    clr_valid = 1'b1;
    clr_ch = 2'd1;
    tick();
    clr_valid = 1'b0;
    model_clear(2'd1);
    checks++; if (rd_data !== 32'h0 || ovf[1] !== 1'b0) begin failures++; $display("FAIL idle_clear acc=%h ovf=%b exp=0/0", rd_data, ovf[1]); end
  endtask

  task automatic test_clear_collision();
    exp_t e;
    rd_ch = 2'd3;
    model_add(2'd3, 32'd7);
    model_clear(2'd3);
    push_exp(2'd3);
    send(2'd3, 32'd7);
    tick();
    clr_valid = 1'b1;
    clr_ch = 2'd3;
    tick();
    clr_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL clr_same_done got=%b exp=1", done); end
    e = pop_exp();
    checks++; if (rd_data !== e.acc || ovf[3] !== e.ovf) begin failures++; $display("FAIL clr_same acc=%h ovf=%b exp=%h/%b", rd_data, ovf[3], e.acc, e.ovf); end
    model_add(2'd3, 32'd7);
    model_clear(2'd0);
    push_exp(2'd3);
    send(2'd3, 32'd7);
    tick();
    clr_valid = 1'b1;
    clr_ch = 2'd0;
    tick();
    clr_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL clr_other_done got=%b exp=1", done); end
    e = pop_exp();
    checks++; if (rd_data !== e.acc) begin failures++; $display("FAIL clr_other_acc3 got=%h exp=%h", rd_data, e.acc); end
    rd_ch = 2'd0;
    #1;
    checks++; if (rd_data !== m_acc[0] || ovf[0] !== m_ovf[0]) begin failures++; $display("FAIL clr_other_acc0 got=%h/%b exp=%h/%b", rd_data, ovf[0], m_acc[0], m_ovf[0]); end
  endtask

  task automatic test_wait0();
    int lat;
    int accepts = 0;
    int dones = 0;
    reset_all();
    rd_ch = 2'd1;
    send(2'd1, 32'd9);
    wait_done(1, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL w0_latency got=%0d exp=1", lat); end
    checks++; if (rd_data_w0 !== 32'd9) begin failures++; $display("FAIL w0_acc1 got=%h exp=00000009", rd_data_w0); end
    in_ch = 2'd1;
    in_value = 32'd9;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (in_ready_w0) accepts++;
      tick();
      if (done_w0) dones++;
    end
    in_valid = 1'b0;
    checks++; if (accepts != 2 || dones != 2) begin failures++; $display("FAIL w0_throughput accepts=%0d dones=%0d exp=2/2", accepts, dones); end
    checks++; if (rd_data_w0 !== 32'd27) begin failures++; $display("FAIL w0_final got=%h exp=0000001b", rd_data_w0); end
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    int dones = 0;
    reset_all();
    rd_ch = 2'd0;
    send(2'd0, 32'd3);
    wait_done(2, lat);
    checks++; if (lat != 5 || rd_data_w4 !== 32'd3) begin failures++; $display("FAIL w4_txn lat=%0d acc=%h exp=5/00000003", lat, rd_data_w4); end
    send(2'd2, 32'h55);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (in_ready_w4 !== 1'b1 || done_w4 !== 1'b0) begin failures++; $display("FAIL w4_after_rst ready=%b done=%b exp=1/0", in_ready_w4, done_w4); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done_w4) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL w4_no_done got=%0d exp=0", dones); end
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      #1;
      checks++; if (rd_data_w4 !== 32'h0) begin failures++; $display("FAIL w4_acc%0d got=%h exp=0", c, rd_data_w4); end
    end
    checks++; if (ovf_w4 !== 4'h0) begin failures++; $display("FAIL w4_ovf got=%h exp=0", ovf_w4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_clear_collision();
    test_wait0();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
